// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory port between
// fetch (I) and data (D) with toggle fairness and a watchdog abort.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ireq,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] irdata,
  output logic          iready,
  input  logic          dreq,
  input  logic          dwe,
  input  logic [AW-1:0] daddr,
  input  logic [DW-1:0] dwdata,
  output logic [DW-1:0] drdata,
  output logic          dready,
  output logic          mreq,
  output logic          mwe,
  output logic [AW-1:0] maddr,
  output logic [DW-1:0] mwdata,
  input  logic [DW-1:0] mrdata,
  input  logic          mready,
  output logic          err,
  output logic          busy
);

  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            last_d_q, last_d_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            mreq_q, mreq_d;
  logic            mwe_q, mwe_d;
  logic [AW-1:0]   maddr_q, maddr_d;
  logic [DW-1:0]   mwdata_q, mwdata_d;
  logic [DW-1:0]   irdata_q, irdata_d;
  logic [DW-1:0]   drdata_q, drdata_d;
  logic            iready_q, iready_d;
  logic            dready_q, dready_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;

  logic hold;
  logic take_d;
  logic take_i;
  logic timeout;
  logic done;

  // grant decision: no grant in a ready cycle, toggle on contention
  always_comb begin
    hold    = iready_q | dready_q;
    take_d  = !hold && dreq && (!ireq || !last_d_q);
    take_i  = !hold && ireq && !take_d;
    timeout = (timer_q == TW'(TIMEOUT - 1));
    done    = mready || timeout;
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (take_d)      state_d = DBUSY;
        else if (take_i) state_d = IBUSY;
      end
      IBUSY, DBUSY: begin
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // output and datapath next values
  always_comb begin
    last_d_d = last_d_q;
    timer_d  = timer_q;
    mreq_d   = mreq_q;
    mwe_d    = mwe_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    irdata_d = irdata_q;
    drdata_d = drdata_q;
    iready_d = 1'b0;
    dready_d = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (take_d) begin
          mreq_d   = 1'b1;
          mwe_d    = dwe;
          maddr_d  = daddr;
          mwdata_d = dwdata;
          last_d_d = 1'b1;
        end else if (take_i) begin
          mreq_d   = 1'b1;
          mwe_d    = 1'b0;
          maddr_d  = iaddr;
          last_d_d = 1'b0;
        end
      end
      IBUSY, DBUSY: begin
        if (done) begin
          mreq_d   = 1'b0;
          timer_d  = '0;
          iready_d = (state_q == IBUSY);
          dready_d = (state_q == DBUSY);
          err_d    = !mready;
          if (mready && state_q == IBUSY)
            irdata_d = mrdata;
          if (mready && state_q == DBUSY && !mwe_q)
            drdata_d = mrdata;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        mreq_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // registered outputs and bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_d_q <= 1'b0;
      timer_q  <= '0;
      mreq_q   <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
      iready_q <= 1'b0;
      dready_q <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      last_d_q <= last_d_d;
      timer_q  <= timer_d;
      mreq_q   <= mreq_d;
      mwe_q    <= mwe_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
      iready_q <= iready_d;
      dready_q <= dready_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign mreq   = mreq_q;
  assign mwe    = mwe_q;
  assign maddr  = maddr_q;
  assign mwdata = mwdata_q;
  assign irdata = irdata_q;
  assign drdata = drdata_q;
  assign iready = iready_q;
  assign dready = dready_q;
  assign err    = err_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ireq = 1'b0;
  logic [AW-1:0] iaddr = '0;
  logic [DW-1:0] irdata;
  logic          iready;
  logic          dreq = 1'b0;
  logic          dwe = 1'b0;
  logic [AW-1:0] daddr = '0;
  logic [DW-1:0] dwdata = '0;
  logic [DW-1:0] drdata;
  logic          dready;
  logic          mreq;
  logic          mwe;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mwdata;
  logic [DW-1:0] mrdata = '0;
  logic          mready = 1'b0;
  logic          err;
  logic          busy;

  int n_checks = 0;
  int n_err = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ireq(ireq), .iaddr(iaddr), .irdata(irdata), .iready(iready),
    .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata),
    .drdata(drdata), .dready(dready),
    .mreq(mreq), .mwe(mwe), .maddr(maddr), .mwdata(mwdata),
    .mrdata(mrdata), .mready(mready),
    .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: which side is being served (0 none, 1 I, 2 D),
  // how long it has waited, a one-cycle rest after each completion,
  // and whose turn it is on contention.
  int            m_srv = 0;
  int            m_age = 0;
  bit            m_rest = 1'b0;
  bit            m_dturn = 1'b1;
  logic          e_mreq = 1'b0;
  logic          e_mwe = 1'b0;
  logic [AW-1:0] e_maddr = '0;
  logic [DW-1:0] e_mwdata = '0;
  logic [DW-1:0] e_irdata = '0;
  logic [DW-1:0] e_drdata = '0;
  logic          e_iready = 1'b0;
  logic          e_dready = 1'b0;
  logic          e_err = 1'b0;
  logic          e_busy = 1'b0;
  int            mem_mode = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_srv = 0; m_age = 0; m_rest = 1'b0; m_dturn = 1'b1;
      e_mreq = 1'b0; e_mwe = 1'b0; e_maddr = '0; e_mwdata = '0;
      e_irdata = '0; e_drdata = '0;
      e_iready = 1'b0; e_dready = 1'b0; e_err = 1'b0; e_busy = 1'b0;
    end else begin
      bit fin;
      bit gd;
      fin = 1'b0;
      e_iready = 1'b0; e_dready = 1'b0; e_err = 1'b0;
      if (m_srv != 0) begin
        if (mready) begin
          if (m_srv == 1) e_irdata = mrdata;
          else if (!e_mwe) e_drdata = mrdata;
          fin = 1'b1;
        end else if (m_age == TO - 1) begin
          e_err = 1'b1;
          fin = 1'b1;
        end else begin
          m_age++;
        end
        if (fin) begin
          e_iready = (m_srv == 1);
          e_dready = (m_srv == 2);
          e_mreq = 1'b0;
          m_srv = 0;
          m_rest = 1'b1;
        end
      end else if (m_rest) begin
        m_rest = 1'b0;
      end else if (ireq || dreq) begin
        gd = dreq && (!ireq || m_dturn);
        m_age = 0;
        e_mreq = 1'b1;
        if (gd) begin
          m_srv = 2; e_mwe = dwe; e_maddr = daddr; e_mwdata = dwdata;
        end else begin
          m_srv = 1; e_mwe = 1'b0; e_maddr = iaddr;
        end
        m_dturn = !gd;
      end
      e_busy = (m_srv != 0);
    end
  end

  // compare DUT outputs with the model on every cycle out of reset
  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("mreq", 32'(mreq), 32'(e_mreq));
      if (e_mreq) begin
        chk("maddr", maddr, e_maddr);
        chk("mwe", 32'(mwe), 32'(e_mwe));
        if (e_mwe) chk("mwdata", mwdata, e_mwdata);
      end
      chk("irdata", irdata, e_irdata);
      chk("drdata", drdata, e_drdata);
      chk("iready", 32'(iready), 32'(e_iready));
      chk("dready", 32'(dready), 32'(e_dready));
      chk("err", 32'(err), 32'(e_err));
      chk("busy", 32'(busy), 32'(e_busy));
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    ireq = 1'b0; dreq = 1'b0; dwe = 1'b0; mready = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
    cyc();
  endtask

  initial begin
    int nh;
    cyc();
    chk("rst_mreq", 32'(mreq), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_maddr", maddr, 0);
    chk("rst_irdata", irdata, 0);
    chk("rst_ready", 32'({iready, dready, err}), 0);
    do_reset();

    // single fetch with two wait cycles
    ireq = 1'b1; iaddr = 32'h40;
    cyc();
    chk("f_mreq1", 32'(mreq), 1);
    chk("f_maddr", maddr, 32'h40);
    chk("f_mwe", 32'(mwe), 0);
    cyc();
    chk("f_mreq2", 32'(mreq), 1);
    cyc();
    chk("f_mreq3", 32'(mreq), 1);
    mready = 1'b1; mrdata = 32'h2408_0005;
    cyc();
    chk("f_iready", 32'(iready), 1);
    chk("f_irdata", irdata, 32'h2408_0005);
    chk("f_mreq_off", 32'(mreq), 0);
    chk("f_err", 32'(err), 0);
    chk("f_model", e_irdata, 32'h2408_0005);
    ireq = 1'b0; mready = 1'b0;
    cyc();
    chk("f_iready_off", 32'(iready), 0);
    chk("f_irdata_hold", irdata, 32'h2408_0005);

    // contention after reset: D first, then I
    do_reset();
    ireq = 1'b1; iaddr = 32'h100;
    dreq = 1'b1; dwe = 1'b1; daddr = 32'h80; dwdata = 32'hDEAD_BEEF;
    cyc();
    chk("c_maddr_d", maddr, 32'h80);
    chk("c_mwe", 32'(mwe), 1);
    chk("c_mwdata", mwdata, 32'hDEAD_BEEF);
    mready = 1'b1; mrdata = 32'h5555_AAAA;
    cyc();
    chk("c_dready", 32'(dready), 1);
    chk("c_iready_early", 32'(iready), 0);
    chk("c_drdata_wr", drdata, 0);
    dreq = 1'b0; mready = 1'b0;
    cyc();
    chk("c_nogrant_rest", 32'(mreq), 0);
    cyc();
    chk("c_maddr_i", maddr, 32'h100);
    mready = 1'b1; mrdata = 32'h0BAD_F00D;
    cyc();
    chk("c_iready", 32'(iready), 1);
    ireq = 1'b0; mready = 1'b0;
    cyc();

    // fairness with both sides held, zero-wait memory
    ireq = 1'b1; iaddr = 32'h300;
    dreq = 1'b1; dwe = 1'b0; daddr = 32'h200;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("fair_addr", maddr, (k % 2 == 0) ? 32'h200 : 32'h300);
      mready = 1'b1; mrdata = 32'hA000 + k;
      cyc();
      if (k % 2 == 0) begin
        chk("fair_dready", 32'(dready), 1);
        chk("fair_drdata", drdata, 32'hA000 + k);
      end else begin
        chk("fair_iready", 32'(iready), 1);
        chk("fair_irdata", irdata, 32'hA000 + k);
      end
      mready = 1'b0;
      if (k == 3) begin ireq = 1'b0; dreq = 1'b0; end
      cyc();
      chk("fair_rest", 32'(mreq), 0);
    end

    // watchdog: read never answered
    do_reset();
    dreq = 1'b1; dwe = 1'b0; daddr = 32'h400;
    cyc();
    nh = 0;
    while (mreq === 1'b1 && nh < 40) begin nh++; cyc(); end
    chk("wd_mreq_cycles", nh, TO);
    chk("wd_err", 32'(err), 1);
    chk("wd_dready", 32'(dready), 1);
    chk("wd_drdata", drdata, 0);
    chk("wd_busy", 32'(busy), 0);
    dreq = 1'b0;
    cyc();
    chk("wd_err_off", 32'(err), 0);

    // mready on the timeout cycle wins
    dreq = 1'b1; dwe = 1'b0; daddr = 32'h404;
    cyc();
    repeat (TO - 1) cyc();
    chk("tie_mreq", 32'(mreq), 1);
    mready = 1'b1; mrdata = 32'h1234_5678;
    cyc();
    chk("tie_dready", 32'(dready), 1);
    chk("tie_err", 32'(err), 0);
    chk("tie_drdata", drdata, 32'h1234_5678);
    mready = 1'b0; dreq = 1'b0;
    cyc();

    // asynchronous reset in the middle of a fetch
    ireq = 1'b1; iaddr = 32'h44;
    cyc();
    chk("rm_mreq_on", 32'(mreq), 1);
    mready = 1'b1; mrdata = 32'hFFFF_0000;
    #1 rst = 1'b0;
    #1;
    chk("rm_mreq", 32'(mreq), 0);
    chk("rm_iready", 32'(iready), 0);
    chk("rm_busy", 32'(busy), 0);
    cyc();
    ireq = 1'b0; rst = 1'b1;
    cyc();
    chk("rm_stale", 32'(mreq), 0);
    chk("rm_stale_rdy", 32'(iready), 0);
    mready = 1'b0; ireq = 1'b1; iaddr = 32'h500;
    cyc();
    chk("rm_regrant", maddr, 32'h500);
    mready = 1'b1; mrdata = 32'hCAFE_0001;
    cyc();
    chk("rm_iready", 32'(iready), 1);
    chk("rm_irdata", irdata, 32'hCAFE_0001);
    ireq = 1'b0; mready = 1'b0;
    cyc();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (e_iready) begin
        ireq = ($urandom_range(0, 1) == 1); iaddr = $urandom;
      end else if (!ireq) begin
        ireq = ($urandom_range(0, 2) == 0); iaddr = $urandom;
      end else if (m_srv == 1 && $urandom_range(0, 3) == 0) begin
        iaddr = $urandom;
      end
      if (e_dready) begin
        dreq = ($urandom_range(0, 1) == 1);
        dwe = ($urandom_range(0, 1) == 1);
        daddr = $urandom; dwdata = $urandom;
      end else if (!dreq) begin
        dreq = ($urandom_range(0, 2) == 0);
        dwe = ($urandom_range(0, 1) == 1);
        daddr = $urandom; dwdata = $urandom;
      end else if (m_srv == 2 && $urandom_range(0, 3) == 0) begin
        dwe = ($urandom_range(0, 1) == 1);
        daddr = $urandom; dwdata = $urandom;
      end
      mrdata = $urandom;
      if (m_srv != 0) begin
        if (m_age == 0) mem_mode = $urandom_range(0, 5);
        case (mem_mode)
          3:       mready = 1'b0;
          4:       mready = (m_age == TO - 1);
          5:       mready = 1'b1;
          default: mready = ($urandom_range(0, 2) == 0);
        endcase
      end else begin
        mready = ($urandom_range(0, 7) == 0);
      end
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
